// File: rtl/algo_nrw_fwd_top_wrap.sv
// N-port read/write wrapper in front of an N-port memory macro: optional input flops,
// write-write arbitration, same-cycle write forwarding, address filtering, matched return pipe.
module algo_nrw_fwd_top_wrap #(
  parameter int unsigned NUMRWPT    = 2,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BITADDR    = 13,
  parameter int unsigned NUMADDR    = 8192,
  parameter int unsigned SRAM_DELAY = 1,
  parameter int unsigned FLOPIN     = 0,
  parameter int unsigned FLOPOUT    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUMRWPT-1:0]         rw_read,
  input  logic [NUMRWPT-1:0]         rw_write,
  input  logic [NUMRWPT*BITADDR-1:0] rw_addr,
  input  logic [NUMRWPT*WIDTH-1:0]   rw_din,
  input  logic [NUMRWPT*WIDTH-1:0]   rw_bw,
  output logic [NUMRWPT-1:0]         rw_vld,
  output logic [NUMRWPT*WIDTH-1:0]   rw_dout,
  output logic [NUMRWPT-1:0]         rw_wcol,
  output logic [NUMRWPT-1:0]         rw_aerr,
  output logic [NUMRWPT-1:0]         t1_read,
  output logic [NUMRWPT-1:0]         t1_write,
  output logic [NUMRWPT*BITADDR-1:0] t1_addr,
  output logic [NUMRWPT*WIDTH-1:0]   t1_din,
  output logic [NUMRWPT*WIDTH-1:0]   t1_bw,
  input  logic [NUMRWPT*WIDTH-1:0]   t1_dout
);

  localparam logic [BITADDR:0] ADDR_LIM = (BITADDR+1)'(NUMADDR);

  logic [NUMRWPT-1:0]         w_rd, w_wr;
  logic [NUMRWPT*BITADDR-1:0] w_addr;
  logic [NUMRWPT*WIDTH-1:0]   w_din, w_bw;

  logic [NUMRWPT-1:0]         w_aerr, w_wok, w_rok, w_wcol, w_wwin, w_fwd;
  logic [NUMRWPT*WIDTH-1:0]   w_fdin, w_fbw;

  logic [NUMRWPT-1:0]         w_pv, w_pf;
  logic [NUMRWPT*WIDTH-1:0]   w_pd, w_pb, w_merged;

  if (FLOPIN != 0) begin : g_flopin
    logic [NUMRWPT-1:0]         r_rd, r_wr;
    logic [NUMRWPT*BITADDR-1:0] r_addr;
    logic [NUMRWPT*WIDTH-1:0]   r_din, r_bw;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd   <= '0;
        r_wr   <= '0;
        r_addr <= '0;
        r_din  <= '0;
        r_bw   <= '0;
      end else begin
        r_rd   <= rw_read;
        r_wr   <= rw_write;
        r_addr <= rw_addr;
        r_din  <= rw_din;
        r_bw   <= rw_bw;
      end
    end
    assign w_rd   = r_rd;
    assign w_wr   = r_wr;
    assign w_addr = r_addr;
    assign w_din  = r_din;
    assign w_bw   = r_bw;
  end else begin : g_noflopin
    assign w_rd   = rw_read;
    assign w_wr   = rw_write;
    assign w_addr = rw_addr;
    assign w_din  = rw_din;
    assign w_bw   = rw_bw;
  end

  always_comb begin
    w_aerr = '0;
    w_wok  = '0;
    w_rok  = '0;
    w_wcol = '0;
    w_wwin = '0;
    w_fwd  = '0;
    w_fdin = '0;
    w_fbw  = '0;
    for (int unsigned p = 0; p < NUMRWPT; p++) begin
      w_aerr[p] = !rst && (w_rd[p] || w_wr[p]) &&
                  ({1'b0, w_addr[p*BITADDR +: BITADDR]} >= ADDR_LIM);
      w_wok[p]  = !rst && w_wr[p] && !w_aerr[p];
      w_rok[p]  = !rst && w_rd[p] && !w_wr[p] && !w_aerr[p];
    end
    // Any lower-indexed in-range write to the same address beats this one.
    for (int unsigned p = 1; p < NUMRWPT; p++) begin
      for (int unsigned i = 0; i < p; i++) begin
        if (w_wok[i] && w_wok[p] &&
            (w_addr[i*BITADDR +: BITADDR] == w_addr[p*BITADDR +: BITADDR]))
          w_wcol[p] = 1'b1;
      end
    end
    w_wwin = w_wok & ~w_wcol;
    for (int unsigned r = 0; r < NUMRWPT; r++) begin
      for (int unsigned w = 0; w < NUMRWPT; w++) begin
        if ((w != r) && w_rok[r] && w_wwin[w] &&
            (w_addr[r*BITADDR +: BITADDR] == w_addr[w*BITADDR +: BITADDR])) begin
          w_fwd[r]                 = 1'b1;
          w_fdin[r*WIDTH +: WIDTH] = w_din[w*WIDTH +: WIDTH];
          w_fbw[r*WIDTH +: WIDTH]  = w_bw[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign t1_read  = w_rok;
  assign t1_write = w_wwin;
  assign rw_aerr  = w_aerr;
  assign rw_wcol  = w_wcol;

  always_comb begin
    t1_addr = '0;
    t1_din  = '0;
    t1_bw   = '0;
    for (int unsigned p = 0; p < NUMRWPT; p++) begin
      if (w_rok[p] || w_wwin[p])
        t1_addr[p*BITADDR +: BITADDR] = w_addr[p*BITADDR +: BITADDR];
      if (w_wwin[p]) begin
        t1_din[p*WIDTH +: WIDTH] = w_din[p*WIDTH +: WIDTH];
        t1_bw[p*WIDTH +: WIDTH]  = w_bw[p*WIDTH +: WIDTH];
      end
    end
  end

  if (SRAM_DELAY == 0) begin : g_nopipe
    assign w_pv = w_rok;
    assign w_pf = w_fwd;
    assign w_pd = w_fdin;
    assign w_pb = w_fbw;
  end else begin : g_pipe
    logic [NUMRWPT-1:0]       r_pv [SRAM_DELAY];
    logic [NUMRWPT-1:0]       r_pf [SRAM_DELAY];
    logic [NUMRWPT*WIDTH-1:0] r_pd [SRAM_DELAY];
    logic [NUMRWPT*WIDTH-1:0] r_pb [SRAM_DELAY];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned s = 0; s < SRAM_DELAY; s++) begin
          r_pv[s] <= '0;
          r_pf[s] <= '0;
          r_pd[s] <= '0;
          r_pb[s] <= '0;
        end
      end else begin
        r_pv[0] <= w_rok;
        r_pf[0] <= w_fwd;
        r_pd[0] <= w_fdin;
        r_pb[0] <= w_fbw;
        for (int unsigned s = 1; s < SRAM_DELAY; s++) begin
          r_pv[s] <= r_pv[s-1];
          r_pf[s] <= r_pf[s-1];
          r_pd[s] <= r_pd[s-1];
          r_pb[s] <= r_pb[s-1];
        end
      end
    end
    assign w_pv = r_pv[SRAM_DELAY-1];
    assign w_pf = r_pf[SRAM_DELAY-1];
    assign w_pd = r_pd[SRAM_DELAY-1];
    assign w_pb = r_pb[SRAM_DELAY-1];
  end

  // The macro returns pre-write data, so the forwarded write is merged in here.
  always_comb begin
    w_merged = t1_dout;
    for (int unsigned p = 0; p < NUMRWPT; p++) begin
      if (w_pf[p])
        w_merged[p*WIDTH +: WIDTH] = (t1_dout[p*WIDTH +: WIDTH] & ~w_pb[p*WIDTH +: WIDTH]) |
                                     (w_pd[p*WIDTH +: WIDTH] & w_pb[p*WIDTH +: WIDTH]);
    end
  end

  if (FLOPOUT != 0) begin : g_flopout
    logic [NUMRWPT-1:0]       r_vld;
    logic [NUMRWPT*WIDTH-1:0] r_dout;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld  <= '0;
        r_dout <= '0;
      end else begin
        r_vld <= w_pv;
        for (int unsigned p = 0; p < NUMRWPT; p++) begin
          if (w_pv[p])
            r_dout[p*WIDTH +: WIDTH] <= w_merged[p*WIDTH +: WIDTH];
        end
      end
    end
    assign rw_vld  = rst ? '0 : r_vld;
    assign rw_dout = rst ? '0 : r_dout;
  end else begin : g_noflopout
    assign rw_vld  = rst ? '0 : w_pv;
    assign rw_dout = rst ? '0 : w_merged;
  end

endmodule

// File: tb/tb_algo_nrw_fwd_top_wrap.sv
// Randomised scoreboard bench for algo_nrw_fwd_top_wrap with a behavioural memory macro
// and a reference model that treats each cycle's winning writes as visible to that cycle's reads.
module tb_algo_nrw_fwd_top_wrap;
  localparam int NP  = 4;
  localparam int W   = 32;
  localparam int BA  = 13;
  localparam int NA  = 6000;
  localparam int SD  = 2;
  localparam int FI  = 1;
  localparam int FO  = 1;
  localparam int LAT = FI + SD + FO;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     rw_read = '0, rw_write = '0;
  logic [NP*BA-1:0]  rw_addr = '0;
  logic [NP*W-1:0]   rw_din = '0, rw_bw = '0;
  logic [NP-1:0]     rw_vld, rw_wcol, rw_aerr, t1_read, t1_write;
  logic [NP*W-1:0]   rw_dout, t1_din, t1_bw, t1_dout;
  logic [NP*BA-1:0]  t1_addr;

  always #5 clk = ~clk;

  algo_nrw_fwd_top_wrap #(
    .NUMRWPT(NP), .WIDTH(W), .BITADDR(BA), .NUMADDR(NA),
    .SRAM_DELAY(SD), .FLOPIN(FI), .FLOPOUT(FO)
  ) dut (
    .clk(clk), .rst(rst),
    .rw_read(rw_read), .rw_write(rw_write), .rw_addr(rw_addr),
    .rw_din(rw_din), .rw_bw(rw_bw),
    .rw_vld(rw_vld), .rw_dout(rw_dout), .rw_wcol(rw_wcol), .rw_aerr(rw_aerr),
    .t1_read(t1_read), .t1_write(t1_write), .t1_addr(t1_addr),
    .t1_din(t1_din), .t1_bw(t1_bw), .t1_dout(t1_dout)
  );

  // Behavioural macro: read-old on same-cycle access, data SD cycles after t1_read.
  logic [W-1:0]    mem [1<<BA] = '{default: '0};
  logic [NP*W-1:0] spipe [SD]  = '{default: '0};
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (t1_read[p]) spipe[0][p*W +: W] <= mem[t1_addr[p*BA +: BA]];
    for (int s = 1; s < SD; s++) spipe[s] <= spipe[s-1];
    for (int p = 0; p < NP; p++)
      if (t1_write[p])
        mem[t1_addr[p*BA +: BA]] <= (mem[t1_addr[p*BA +: BA]] & ~t1_bw[p*W +: W]) |
                                    (t1_din[p*W +: W] & t1_bw[p*W +: W]);
  end
  assign t1_dout = spipe[SD-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [NP-1:0] rd, wr, aerr, wcol; } iss_t;
  typedef struct { int cyc; logic [W-1:0] data; } rdx_t;
  iss_t         iq [$];
  rdx_t         rq [NP][$];
  logic [W-1:0] ref_mem [1<<BA] = '{default: '0};
  int checks = 0;
  int errors = 0;

  logic [NP-1:0]    s_rd = '0, s_wr = '0;
  logic [NP*BA-1:0] s_ad = '0;
  logic [NP*W-1:0]  s_di = '0, s_bw = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NP-1:0] rd, input logic [NP-1:0] wr,
                       input logic [NP*BA-1:0] ad, input logic [NP*W-1:0] di,
                       input logic [NP*W-1:0] bw);
    logic [NP-1:0] aerr, wcol, win, rok;
    int a [NP];
    int claimed [int];
    rw_read = rd; rw_write = wr; rw_addr = ad; rw_din = di; rw_bw = bw;
    aerr = '0; wcol = '0; win = '0;
    for (int p = 0; p < NP; p++) begin
      a[p] = int'(ad[p*BA +: BA]);
      aerr[p] = (rd[p] || wr[p]) && (a[p] >= NA);
      if (wr[p] && !aerr[p]) begin
        if (claimed.exists(a[p])) wcol[p] = 1'b1;
        else begin claimed[a[p]] = p; win[p] = 1'b1; end
      end
    end
    for (int p = 0; p < NP; p++)
      if (win[p])
        ref_mem[a[p]] = (ref_mem[a[p]] & ~bw[p*W +: W]) | (di[p*W +: W] & bw[p*W +: W]);
    rok = rd & ~wr & ~aerr;
    for (int p = 0; p < NP; p++)
      if (rok[p]) rq[p].push_back(rdx_t'{cyc + LAT, ref_mem[a[p]]});
    iq.push_back(iss_t'{cyc + FI, rok, win, aerr, wcol});
  endtask

  task automatic put(input int p, input bit rd, input bit wr, input int ad,
                     input logic [W-1:0] di, input logic [W-1:0] bw);
    s_rd[p] = rd; s_wr[p] = wr;
    s_ad[p*BA +: BA] = BA'(ad);
    s_di[p*W +: W] = di; s_bw[p*W +: W] = bw;
  endtask

  task automatic fire();
    drive(s_rd, s_wr, s_ad, s_di, s_bw);
    s_rd = '0; s_wr = '0; s_ad = '0; s_di = '0; s_bw = '0;
  endtask

  function automatic int pick_addr();
    int r;
    r = $urandom_range(0, 11);
    case (r)
      8:       return 5999;
      9:       return 6000;
      10:      return 8191;
      11:      return $urandom_range(0, 5999);
      default: return r;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_bw();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return 32'h0000FFFF;
      2:       return '0;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      for (int p = 0; p < NP; p++)
        put(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), pick_addr(),
            $urandom, pick_bw());
      fire();
    end
  endtask

  task automatic chk(input string name, input int p, input logic [W-1:0] got,
                     input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s port %0d cycle %0d got %h want %h", name, p, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    iss_t e;
    rdx_t r;
    if (rst)
      chk("reset_zero", -1,
          W'(t1_read | t1_write | rw_vld | rw_aerr | rw_wcol | (|rw_dout) | (|t1_addr)), '0);
    while (iq.size() > 0 && iq[0].cyc < cyc) begin
      e = iq.pop_front();
      chk("issue_missed", -1, W'(e.cyc), W'(cyc));
    end
    if (iq.size() > 0 && iq[0].cyc == cyc) begin
      e = iq.pop_front();
      chk("t1_read", -1, W'(t1_read), W'(e.rd));
      chk("t1_write", -1, W'(t1_write), W'(e.wr));
      chk("rw_aerr", -1, W'(rw_aerr), W'(e.aerr));
      chk("rw_wcol", -1, W'(rw_wcol), W'(e.wcol));
    end
    for (int p = 0; p < NP; p++) begin
      if (rw_vld[p]) begin
        if (rq[p].size() == 0) chk("unexpected_vld", p, 32'd1, 32'd0);
        else begin
          r = rq[p].pop_front();
          chk("vld_cycle", p, W'(cyc), W'(r.cyc));
          chk("rw_dout", p, rw_dout[p*W +: W], r.data);
        end
      end
      while (rq[p].size() > 0 && rq[p][0].cyc < cyc) begin
        r = rq[p].pop_front();
        chk("missing_vld", p, W'(cyc), W'(r.cyc));
      end
    end
  end

  initial begin
    logic [NP*BA-1:0] ad;
    repeat (3) step();
    rst = 1'b0;

    step(); put(0, 0, 1, 5, 32'hDEADBEEF, '1); fire();
    step(); put(1, 1, 0, 5, '0, '0); fire();
    step(); put(0, 0, 1, 9, 32'h1111, '1); put(1, 0, 1, 9, 32'h2222, '1); fire();
    step(); put(0, 0, 1, 3, 32'hFFFF0000, '1); put(2, 1, 0, 9, '0, '0); fire();
    step(); put(0, 0, 1, 3, 32'h0000ABCD, 32'h0000FFFF); put(1, 1, 0, 3, '0, '0); fire();
    step(); put(1, 1, 0, 6000, '0, '0); put(2, 1, 0, 8191, '0, '0);
            put(3, 1, 1, 7, 32'h5A5A, '1); put(0, 1, 0, 7, '0, '0); fire();

    // Every port reads every cycle: full throughput with no stalls.
    for (int i = 0; i < 100; i++) begin
      step();
      for (int p = 0; p < NP; p++) ad[p*BA +: BA] = BA'($urandom_range(0, 7));
      drive('1, '0, ad, '0, '0);
    end

    rand_cycles(150);

    // Reset while reads are in flight: those reads must never return.
    step(); drive('0, '0, '0, '0, '0);
    step(); rst = 1'b1;
    for (int p = 0; p < NP; p++)
      while (rq[p].size() > 0 && rq[p][$].cyc >= cyc) void'(rq[p].pop_back());
    drive('0, '0, '0, '0, '0);
    step(); drive('0, '0, '0, '0, '0);
    step(); rst = 1'b0; drive('0, '0, '0, '0, '0);

    rand_cycles(150);

    step(); drive('0, '0, '0, '0, '0);
    repeat (LAT + 3) step();
    for (int p = 0; p < NP; p++) chk("drain_empty", p, W'(rq[p].size()), '0);
    chk("issue_drain_empty", -1, W'(iq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
